// File: rtl/ps2_host_tx_if.sv
// Request/status bundle between a command source and the PS/2 host transmitter.
// The source drives tx_data/tx_valid; the transmitter reports progress and outcome.
`timescale 1ns/1ps
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       error;
   logic       rx_inhibit;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, busy, done, error, rx_inhibit
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, busy, done, error, rx_inhibit
   );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends start/data/parity/stop on the
// device's clock, checks the device ACK and reports done or error; pins are open-drain.
`timescale 1ns/1ps
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 1200,
   parameter int TIMEOUT_CYCLES = 150000
) (
   input  logic         clk,
   input  logic         reset,
   ps2_host_tx_if.slave tx,
   input  logic         ps2_clk_in,
   input  logic         ps2_dat_in,
   output logic         ps2_clk_oe,
   output logic         ps2_dat_oe
);
   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [3:0]       LAST_BIT     = 4'd9;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INHIBIT = 3'd1,
      ST_START   = 3'd2,
      ST_SEND    = 3'd3,
      ST_ACK     = 3'd4,
      ST_RELEASE = 3'd5
   } state_t;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

   state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic [3:0]       bit_idx_r, bit_idx_nxt_s;
   logic [9:0]       frame_r, frame_nxt_s;
   logic             clk_meta_r, clk_sync_r, clk_prev_r;
   logic             dat_meta_r, dat_sync_r;
   logic             fe_s, timeout_s, line_idle_s;
   logic             clk_oe_r, clk_oe_nxt_s;
   logic             dat_oe_r, dat_oe_nxt_s;
   logic             tx_ready_r, tx_ready_nxt_s;
   logic             busy_r, busy_nxt_s;
   logic             done_r, done_nxt_s;
   logic             error_r, error_nxt_s;

   // Two-flop synchronisers for both pins plus the previous clock level for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_meta_r <= 1'b1;
         clk_sync_r <= 1'b1;
         clk_prev_r <= 1'b1;
         dat_meta_r <= 1'b1;
         dat_sync_r <= 1'b1;
      end else begin
         clk_meta_r <= ps2_clk_in;
         clk_sync_r <= clk_meta_r;
         clk_prev_r <= clk_sync_r;
         dat_meta_r <= ps2_dat_in;
         dat_sync_r <= dat_meta_r;
      end
   end

   assign fe_s        = clk_prev_r & ~clk_sync_r;
   assign timeout_s   = (cnt_r == TIMEOUT_LAST);
   assign line_idle_s = clk_sync_r & dat_sync_r;

   // State register together with the registered datapath and outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= CNT_ZERO;
         bit_idx_r  <= 4'd0;
         frame_r    <= 10'd0;
         clk_oe_r   <= 1'b0;
         dat_oe_r   <= 1'b0;
         tx_ready_r <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         bit_idx_r  <= bit_idx_nxt_s;
         frame_r    <= frame_nxt_s;
         clk_oe_r   <= clk_oe_nxt_s;
         dat_oe_r   <= dat_oe_nxt_s;
         tx_ready_r <= tx_ready_nxt_s;
         busy_r     <= busy_nxt_s;
         done_r     <= done_nxt_s;
         error_r    <= error_nxt_s;
      end
   end

   // Next-state logic; a device edge takes priority over a timeout in the same cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (tx.tx_valid) state_nxt_s = ST_INHIBIT;
            else             state_nxt_s = ST_IDLE;
         end
         ST_INHIBIT: begin
            if (cnt_r == INHIBIT_LAST) state_nxt_s = ST_START;
            else                       state_nxt_s = ST_INHIBIT;
         end
         ST_START: state_nxt_s = ST_SEND;
         ST_SEND: begin
            if (fe_s) begin
               if (bit_idx_r == LAST_BIT) state_nxt_s = ST_ACK;
               else                       state_nxt_s = ST_SEND;
            end else if (timeout_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_SEND;
            end
         end
         ST_ACK: begin
            if (fe_s) begin
               if (dat_sync_r) state_nxt_s = ST_IDLE;
               else            state_nxt_s = ST_RELEASE;
            end else if (timeout_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ACK;
            end
         end
         ST_RELEASE: begin
            if (line_idle_s)    state_nxt_s = ST_IDLE;
            else if (timeout_s) state_nxt_s = ST_IDLE;
            else                state_nxt_s = ST_RELEASE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output and datapath next values; the frame register shifts out LSB first on each device edge.
   always_comb begin
      bit_idx_nxt_s  = bit_idx_r;
      frame_nxt_s    = frame_r;
      dat_oe_nxt_s   = 1'b0;
      done_nxt_s     = 1'b0;
      error_nxt_s    = 1'b0;
      clk_oe_nxt_s   = (state_nxt_s == ST_INHIBIT) || (state_nxt_s == ST_START);
      tx_ready_nxt_s = (state_nxt_s == ST_IDLE);
      busy_nxt_s     = (state_nxt_s != ST_IDLE);

      if (state_nxt_s != state_r) begin
         cnt_nxt_s = CNT_ZERO;
      end else if (state_r == ST_IDLE) begin
         cnt_nxt_s = CNT_ZERO;
      end else if (fe_s && (state_r inside {ST_SEND, ST_ACK, ST_RELEASE})) begin
         cnt_nxt_s = CNT_ZERO;
      end else begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end

      case (state_r)
         ST_IDLE: begin
            bit_idx_nxt_s = 4'd0;
            if (tx.tx_valid) frame_nxt_s = {1'b1, odd_parity(tx.tx_data), tx.tx_data};
            else             frame_nxt_s = frame_r;
         end
         ST_INHIBIT: dat_oe_nxt_s = (state_nxt_s == ST_START);
         ST_START:   dat_oe_nxt_s = 1'b1;
         ST_SEND: begin
            if (state_nxt_s == ST_IDLE) begin
               error_nxt_s = 1'b1;
            end else if (fe_s) begin
               dat_oe_nxt_s  = ~frame_r[0];
               frame_nxt_s   = {1'b0, frame_r[9:1]};
               bit_idx_nxt_s = bit_idx_r + 4'd1;
            end else begin
               dat_oe_nxt_s = dat_oe_r;
            end
         end
         ST_ACK: begin
            if (state_nxt_s == ST_IDLE) error_nxt_s = 1'b1;
            else                        error_nxt_s = 1'b0;
         end
         ST_RELEASE: begin
            if (state_nxt_s != ST_IDLE) begin
               done_nxt_s = 1'b0;
            end else if (line_idle_s) begin
               done_nxt_s = 1'b1;
            end else begin
               error_nxt_s = 1'b1;
            end
         end
         default: dat_oe_nxt_s = 1'b0;
      endcase
   end

   assign ps2_clk_oe    = clk_oe_r;
   assign ps2_dat_oe    = dat_oe_r;
   assign tx.tx_ready   = tx_ready_r;
   assign tx.busy       = busy_r;
   assign tx.rx_inhibit = busy_r;
   assign tx.done       = done_r;
   assign tx.error      = error_r;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model (~12 kHz clock) receives frames and compares them
// with a frame built directly from the byte; outcome pulses, timing and line release are checked.
`timescale 1ns/1ps
module tb_ps2_host_tx;
   localparam int INHIBIT = 20;
   localparam int TIMEOUT = 2000;

   logic clk = 1'b0;
   logic reset;
   logic dev_clk_low, dev_dat_low;
   logic ps2_clk_oe, ps2_dat_oe;
   logic clk_line, dat_line;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int done_cnt = 0, err_cnt = 0, err_cyc = 0;
   int both_cnt = 0, inh_mis = 0, dual_pulse = 0;
   int n_accepts = 0;

   logic [7:0] d;
   logic [9:0] got;
   int         lf;

   ps2_host_tx_if bus();

   assign clk_line = ~(ps2_clk_oe | dev_clk_low);
   assign dat_line = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .tx         (bus),
      .ps2_clk_in (clk_line),
      .ps2_dat_in (dat_line),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   always #50 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse counters and always-true line invariants.
   always @(negedge clk) begin
      if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
      if (bus.error === 1'b1) begin
         err_cnt <= err_cnt + 1;
         err_cyc <= cyc;
      end
      if (ps2_clk_oe && ps2_dat_oe) both_cnt <= both_cnt + 1;
      if (bus.rx_inhibit !== bus.busy) inh_mis <= inh_mis + 1;
      if (bus.done && bus.error) dual_pulse <= dual_pulse + 1;
   end

   initial begin
      #12_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference frame: data LSB first, odd parity, stop bit, as the device should see it.
   function automatic logic [9:0] frame_model(input logic [7:0] b);
      logic p;
      p = (($countones(b) % 2) == 0);
      return {1'b1, p, b};
   endfunction

   task automatic accept(input logic [7:0] b, input string tag);
      int t, w, rc, rd, fc;
      @(negedge clk);
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      w = 0;
      while (bus.tx_ready !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      check_eq($sformatf("accept_%s", tag), bus.tx_ready, 1);
      t  = cyc;
      rc = -1; rd = -1; fc = -1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'($urandom);
      check_eq($sformatf("busy_%s", tag), bus.busy, 1);
      for (int k = 0; k < 26; k++) begin
         if (ps2_clk_oe && rc < 0) rc = cyc;
         if (ps2_dat_oe && rd < 0) rd = cyc;
         if (!ps2_clk_oe && rc >= 0 && fc < 0) fc = cyc;
         @(negedge clk);
      end
      check_eq($sformatf("clk_oe_rise_%s", tag), rc - t, 1);
      check_eq($sformatf("dat_oe_rise_%s", tag), rd - t, INHIBIT + 1);
      check_eq($sformatf("clk_oe_fall_%s", tag), fc - t, INHIBIT + 2);
      n_accepts++;
   endtask

   // Device model: waits for request-to-send, clocks nclk pulses, samples data on rising edges,
   // and on the eleventh pulse optionally pulls data low as ACK.
   task automatic dev_frame(input int nclk, input bit do_ack, output logic [9:0] bits, output int last_fall);
      int w, half;
      bits = 10'd0;
      last_fall = cyc;
      w = 0;
      while (!(ps2_clk_oe == 1'b0 && dat_line == 1'b0) && w < 200) begin
         @(negedge clk);
         w++;
      end
      check_eq("request_to_send", (w < 200), 1);
      for (int i = 0; i < nclk; i++) begin
         half = 400 + int'($urandom_range(0, 20));
         if (i == 10) begin
            repeat (half / 2) @(negedge clk);
            dev_dat_low = do_ack;
            repeat (half - half / 2) @(negedge clk);
         end else begin
            repeat (half) @(negedge clk);
         end
         dev_clk_low = 1'b1;
         last_fall   = cyc;
         repeat (half) @(negedge clk);
         dev_clk_low = 1'b0;
         if (i < 10) bits[i] = dat_line;
      end
      if (nclk == 11) begin
         repeat (20) @(negedge clk);
         dev_dat_low = 1'b0;
      end
   endtask

   task automatic wait_outcome(input int d0, input int e0, input bit exp_done, input string tag);
      for (int k = 0; k < 3000; k++) begin
         if (done_cnt != d0 || err_cnt != e0) break;
         @(negedge clk);
         if (bus.done || bus.error) begin
            @(negedge clk);
            check_eq($sformatf("ready_after_pulse_%s", tag), bus.tx_ready, 1);
            check_eq($sformatf("pulse_one_cycle_%s", tag), {bus.done, bus.error}, 2'b00);
            break;
         end
      end
      repeat (20) @(negedge clk);
      check_eq($sformatf("done_count_%s", tag), done_cnt - d0, exp_done ? 1 : 0);
      check_eq($sformatf("error_count_%s", tag), err_cnt - e0, exp_done ? 0 : 1);
      check_eq($sformatf("idle_%s", tag), {bus.tx_ready, bus.busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);
   endtask

   task automatic run_frame(input logic [7:0] b, input bit ack, input string tag, output logic [9:0] bits);
      int d0, e0, fall;
      d0 = done_cnt;
      e0 = err_cnt;
      accept(b, tag);
      dev_frame(11, ack, bits, fall);
      check_eq($sformatf("frame_%s", tag), bits, frame_model(b));
      wait_outcome(d0, e0, ack, tag);
   endtask

   initial begin
      logic [7:0] bytes_t [3];
      logic       par_t   [3];
      int         d0, e0;
      bytes_t = '{8'h00, 8'hFF, 8'h01};
      par_t   = '{1'b1, 1'b1, 1'b0};

      reset        = 1'b1;
      dev_clk_low  = 1'b0;
      dev_dat_low  = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_eq("reset_state",
               {bus.tx_ready, bus.busy, bus.done, bus.error, bus.rx_inhibit, ps2_clk_oe, ps2_dat_oe},
               7'b1000000);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      run_frame(8'hED, 1'b1, "ed", got);
      check_eq("ed_bits", got, 10'b11_1110_1101);

      for (int i = 0; i < 3; i++) begin
         run_frame(bytes_t[i], 1'b1, $sformatf("b%02h", bytes_t[i]), got);
         check_eq($sformatf("parity_%02h", bytes_t[i]), got[8], par_t[i]);
      end

      // Device stops clocking after four bits.
      d  = 8'($urandom);
      d0 = done_cnt;
      e0 = err_cnt;
      accept(d, "stall");
      dev_frame(4, 1'b0, got, lf);
      check_eq("stall_bits", got[3:0], d[3:0]);
      wait_outcome(d0, e0, 1'b0, "stall");
      check_eq("timeout_window", ((err_cyc - lf) >= TIMEOUT) && ((err_cyc - lf) <= TIMEOUT + 6), 1);

      // Device answers with NACK.
      run_frame(8'($urandom), 1'b0, "nack", got);

      // Reset in the middle of SEND with bit 4 = 0 on the line.
      d = 8'($urandom) & 8'hEF;
      accept(d, "pre_reset");
      dev_frame(5, 1'b0, got, lf);
      repeat (10) @(negedge clk);
      check_eq("pre_reset_dat_oe", ps2_dat_oe, 1);
      check_eq("pre_reset_busy", bus.busy, 1);
      reset = 1'b1;
      #1;
      check_eq("reset_async_release", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
      check_eq("reset_async_ready", {bus.tx_ready, bus.busy}, 2'b10);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      run_frame(8'hF4, 1'b1, "f4", got);

      check_eq("start_bit_overlap_cycles", both_cnt, n_accepts);
      check_eq("rx_inhibit_follows_busy", inh_mis, 0);
      check_eq("done_error_exclusive", dual_pulse, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
